alu_operand_entry: RTL and testbench
====================================

ALU_OPERAND_ENTRY -- requirements
Module: alu_operand_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, stable-level cycles needed to accept a button change; legal range 2..65535.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 sw  input  4  nibble entry switches, asynchronous to clock.
REQ-005 enter  input  1  raw push-button (active-high): commit current sw nibble.
REQ-006 clear  input  1  raw push-button (active-high): abort entry, restart at operand A.
REQ-007 ack  input  1  consumer accepts presented operand set.
REQ-008 data1  output  16  assembled operand A.
REQ-009 data2  output  16  assembled operand B.
REQ-010 opcode1  output  4  first opcode nibble.
REQ-011 opcode2  output  4  second opcode nibble.
REQ-012 valid  output  1  operand set complete and held stable.
REQ-013 phase  output  2  0=LOAD_A, 1=LOAD_B, 2=LOAD_OP, 3=PRESENT.
REQ-014 nib_idx  output  2  nibbles already committed in current phase.

Function
REQ-015 sw, enter, clear SHALL each pass through a 2-flop synchronizer before any use.
REQ-016 Per button: debounced level changes only after synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any intermediate match restarts the count.
REQ-017 Debounced 0->1 transition SHALL produce exactly one 1-cycle pulse (enter_p / clear_p) in the cycle the debounced level changes; release produces no pulse.
REQ-018 On enter_p, the synchronized sw value in that same cycle is the committed nibble.
REQ-019 Nibbles shift in MSN first: target <= {target[11:0], sw} for data1/data2.
REQ-020 LOAD_A: 4 commits into data1, nib_idx 0->3; 4th commit -> LOAD_B, nib_idx=0.
REQ-021 LOAD_B: 4 commits into data2; 4th commit -> LOAD_OP, nib_idx=0.
REQ-022 LOAD_OP: 1st commit -> opcode1, 2nd -> opcode2 and -> PRESENT; valid=1 from the cycle after the 2nd commit.
REQ-023 PRESENT: valid held 1, data1/data2/opcode1/opcode2 frozen; enter_p ignored.
REQ-024 ack=1 in PRESENT: next cycle valid=0, phase=LOAD_A, nib_idx=0, data1/data2/opcodes zeroed.
REQ-025 ack outside PRESENT SHALL be ignored.
REQ-026 clear_p in any phase: next cycle same state as REQ-024 (valid=0, all operands zero, LOAD_A).
REQ-027 clear_p and enter_p in same cycle: clear wins, nibble discarded.
REQ-028 clear_p and ack in same cycle in PRESENT: identical result (LOAD_A, zeros).
REQ-029 data1/data2 update only in their own load phase; other operands unaffected by commits.
REQ-030 Held button (no release) SHALL never generate a second enter_p.

Reset
REQ-031 reset=0 at a rising edge: phase=0, nib_idx=0, valid=0, data1=data2=0, opcode1=opcode2=0, debounced levels=0, debounce counters=0, synchronizers=0.
REQ-032 Reset asserted mid-entry or in PRESENT discards all partial data; a button held through reset release produces a pulse only after DEBOUNCE_CYCLES stable cycles post-reset.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Clean entry: enter presses with sw=1,2,3,4,A,B,C,D,5,6 -> data1=0x1234, data2=0xABCD, opcode1=5, opcode2=6, valid=1, phase=3.
REQ-034 Bounce: enter toggled 1,0,1,0 each 1 cycle then held 1 -> exactly one commit, pulse 2(sync)+4 cycles after the stable high begins.
REQ-035 Handshake: in PRESENT, 10 extra enter presses with sw=F -> no output change; ack=1 one cycle -> valid=0, phase=0, all operands 0.
REQ-036 Clear mid-entry: commit 3 nibbles of A, press clear -> phase=0, nib_idx=0, data1=0; then 4 commits of 0x7 -> data1=0x7777.
REQ-037 Simultaneous: enter and clear debounced in same cycle during LOAD_B -> phase=0, data2=0, no nibble committed.
REQ-038 Reset in PRESENT with enter held -> valid=0 immediately after edge; no commit until enter released and re-pressed, or held 4 stable cycles after release of reset.

Source files
------------

// File: rtl/alu_operand_entry.sv
// Operand entry front-end: synchronizes and debounces switch/button inputs, then
// assembles two 16-bit operands and two opcode nibbles for a downstream ALU consumer.
module alu_operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  sw,
  input  logic        enter,
  input  logic        clear,
  input  logic        ack,
  output logic [15:0] data1,
  output logic [15:0] data2,
  output logic [3:0]  opcode1,
  output logic [3:0]  opcode2,
  output logic        valid,
  output logic [1:0]  phase,
  output logic [1:0]  nib_idx
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned NIB_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    PRESENT = 2'd3
  } state_t;

  logic [NIB_W-1:0] sw_s1, sw_s2;
  logic             en_s1, en_s2, cl_s1, cl_s2;
  logic             en_db, cl_db;
  logic [CNT_W-1:0] en_cnt, cl_cnt;
  logic             enter_p_c, clear_p_c;

  state_t      state, state_n;
  logic [1:0]  nib_n;
  logic [15:0] data1_n, data2_n;
  logic [3:0]  opcode1_n, opcode2_n;

  // Two-flop synchronizers for all asynchronous inputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      en_s1 <= 1'b0;
      en_s2 <= 1'b0;
      cl_s1 <= 1'b0;
      cl_s2 <= 1'b0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      en_s1 <= enter;
      en_s2 <= en_s1;
      cl_s1 <= clear;
      cl_s2 <= cl_s1;
    end
  end

  // Debouncers: level flips after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clock) begin
    if (!reset) begin
      en_db  <= 1'b0;
      en_cnt <= '0;
      cl_db  <= 1'b0;
      cl_cnt <= '0;
    end else begin
      if (en_s2 != en_db) begin
        if (en_cnt == CNT_LAST) begin
          en_db  <= en_s2;
          en_cnt <= '0;
        end else begin
          en_cnt <= en_cnt + CNT_W'(1);
        end
      end else begin
        en_cnt <= '0;
      end
      if (cl_s2 != cl_db) begin
        if (cl_cnt == CNT_LAST) begin
          cl_db  <= cl_s2;
          cl_cnt <= '0;
        end else begin
          cl_cnt <= cl_cnt + CNT_W'(1);
        end
      end else begin
        cl_cnt <= '0;
      end
    end
  end

  // Press pulses fire in the cycle whose edge raises the debounced level
  assign enter_p_c = en_s2 & ~en_db & (en_cnt == CNT_LAST);
  assign clear_p_c = cl_s2 & ~cl_db & (cl_cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= LOAD_A;
      nib_idx <= 2'd0;
      data1   <= '0;
      data2   <= '0;
      opcode1 <= '0;
      opcode2 <= '0;
      valid   <= 1'b0;
    end else begin
      state   <= state_n;
      nib_idx <= nib_n;
      data1   <= data1_n;
      data2   <= data2_n;
      opcode1 <= opcode1_n;
      opcode2 <= opcode2_n;
      valid   <= (state_n == PRESENT);
    end
  end

  always_comb begin
    state_n   = state;
    nib_n     = nib_idx;
    data1_n   = data1;
    data2_n   = data2;
    opcode1_n = opcode1;
    opcode2_n = opcode2;
    if (clear_p_c || (state == PRESENT && ack)) begin
      // Clear beats a simultaneous commit; ack only matters while presenting
      state_n   = LOAD_A;
      nib_n     = 2'd0;
      data1_n   = '0;
      data2_n   = '0;
      opcode1_n = '0;
      opcode2_n = '0;
    end else if (enter_p_c) begin
      case (state)
        LOAD_A: begin
          data1_n = {data1[11:0], sw_s2};
          nib_n   = nib_idx + 2'd1;
          if (nib_idx == 2'd3) state_n = LOAD_B;
        end
        LOAD_B: begin
          data2_n = {data2[11:0], sw_s2};
          nib_n   = nib_idx + 2'd1;
          if (nib_idx == 2'd3) state_n = LOAD_OP;
        end
        LOAD_OP: begin
          if (nib_idx == 2'd0) begin
            opcode1_n = sw_s2;
            nib_n     = 2'd1;
          end else begin
            opcode2_n = sw_s2;
            nib_n     = 2'd0;
            state_n   = PRESENT;
          end
        end
        default: ;
      endcase
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Directed bench for alu_operand_entry with DEBOUNCE_CYCLES=4; inputs driven and
// outputs sampled on the falling clock edge.
module tb_alu_operand_entry;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  sw;
  logic        enter, clear, ack;
  logic [15:0] data1, data2;
  logic [3:0]  opcode1, opcode2;
  logic        valid;
  logic [1:0]  phase, nib_idx;

  int checks = 0;
  int passed = 0;
  int cyc;

  alu_operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .sw(sw), .enter(enter), .clear(clear), .ack(ack),
    .data1(data1), .data2(data2), .opcode1(opcode1), .opcode2(opcode2),
    .valid(valid), .phase(phase), .nib_idx(nib_idx)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic press(input logic [3:0] nib);
    @(negedge clock);
    sw = nib;
    enter = 1'b1;
    repeat (8) @(negedge clock);
    enter = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic press_clear();
    @(negedge clock);
    clear = 1'b1;
    repeat (8) @(negedge clock);
    clear = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; sw = 4'h0; enter = 1'b0; clear = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_phase", 16'(phase), 16'h0);
    check("rst_nib", 16'(nib_idx), 16'h0);
    check("rst_valid", 16'(valid), 16'h0);
    check("rst_data1", data1, 16'h0);
    check("rst_data2", data2, 16'h0);
    check("rst_ops", {8'h0, opcode1, opcode2}, 16'h0);
    reset = 1'b1;

    // Clean entry of a full operand set
    press(4'h1); press(4'h2); press(4'h3);
    check("a3_data1", data1, 16'h0123);
    check("a3_nib", 16'(nib_idx), 16'd3);
    check("a3_phase", 16'(phase), 16'd0);
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    check("ack_ignored_data1", data1, 16'h0123);
    check("ack_ignored_phase", 16'(phase), 16'd0);
    press(4'h4);
    check("a4_data1", data1, 16'h1234);
    check("a4_phase", 16'(phase), 16'd1);
    check("a4_nib", 16'(nib_idx), 16'd0);
    press(4'hA); press(4'hB); press(4'hC); press(4'hD);
    check("b_data2", data2, 16'hABCD);
    check("b_data1_kept", data1, 16'h1234);
    check("b_phase", 16'(phase), 16'd2);
    press(4'h5);
    check("op1", 16'(opcode1), 16'h5);
    check("op1_nib", 16'(nib_idx), 16'd1);
    check("op1_valid", 16'(valid), 16'h0);
    press(4'h6);
    check("op2", 16'(opcode2), 16'h6);
    check("pres_valid", 16'(valid), 16'h1);
    check("pres_phase", 16'(phase), 16'd3);

    // Presses while presenting are ignored
    for (int i = 0; i < 10; i++) press(4'hF);
    check("hold_data1", data1, 16'h1234);
    check("hold_data2", data2, 16'hABCD);
    check("hold_ops", {8'h0, opcode1, opcode2}, 16'h0056);
    check("hold_valid", 16'(valid), 16'h1);
    @(negedge clock);
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    check("ack_valid", 16'(valid), 16'h0);
    check("ack_phase", 16'(phase), 16'd0);
    check("ack_data", data1 | data2, 16'h0);
    check("ack_ops", {8'h0, opcode1, opcode2}, 16'h0);

    // Clear in the middle of operand A
    press(4'h1); press(4'h2); press(4'h3);
    press_clear();
    check("clr_phase", 16'(phase), 16'd0);
    check("clr_nib", 16'(nib_idx), 16'd0);
    check("clr_data1", data1, 16'h0);
    for (int i = 0; i < 4; i++) press(4'h7);
    check("clr_refill", data1, 16'h7777);
    check("clr_refill_phase", 16'(phase), 16'd1);

    // Enter and clear debounced together in LOAD_B
    press(4'hA);
    check("b1_data2", data2, 16'h000A);
    @(negedge clock);
    sw = 4'h3; enter = 1'b1; clear = 1'b1;
    repeat (8) @(negedge clock);
    enter = 1'b0; clear = 1'b0;
    repeat (8) @(negedge clock);
    check("sim_phase", 16'(phase), 16'd0);
    check("sim_data2", data2, 16'h0);
    check("sim_data1", data1, 16'h0);
    check("sim_nib", 16'(nib_idx), 16'd0);

    // Bouncy press: one commit, 2+4 cycles after the stable high starts
    @(negedge clock); sw = 4'h9; enter = 1'b1;
    @(negedge clock); enter = 1'b0;
    @(negedge clock); enter = 1'b1;
    @(negedge clock); enter = 1'b0;
    @(negedge clock); enter = 1'b1;
    cyc = 0;
    while (nib_idx == 2'd0 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("bounce_latency", 16'(cyc), 16'd6);
    check("bounce_data1", data1, 16'h0009);
    repeat (12) @(negedge clock);
    check("held_no_repeat", 16'(nib_idx), 16'd1);
    enter = 1'b0;
    repeat (8) @(negedge clock);

    // Reset while presenting with enter held
    press_clear();
    for (int i = 0; i < 10; i++) press(4'(i));
    check("pre_rst_valid", 16'(valid), 16'h1);
    @(negedge clock);
    sw = 4'hE; enter = 1'b1; reset = 1'b0;
    @(negedge clock);
    check("rst2_valid", 16'(valid), 16'h0);
    check("rst2_phase", 16'(phase), 16'd0);
    check("rst2_data", data1 | data2, 16'h0);
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check("rst2_no_early", 16'(nib_idx), 16'd0);
    cyc = 0;
    while (nib_idx == 2'd0 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("rst2_commit", 16'(nib_idx), 16'd1);
    check("rst2_data1", data1, 16'h000E);
    enter = 1'b0;
    repeat (8) @(negedge clock);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
